// File: rtl/ahb_lite_master_port_if.sv
// Bundle of the command, response and AHB-Lite signals of one initiator port.
// Latency: none, wires only.
// Backpressure: cmd_valid/cmd_ready on the command side; HREADY stalls the bus side.
interface ahb_lite_master_port_if;
    // client command
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    // client response
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    // AHB-Lite
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_lite_master_port.sv
// Single-transfer AHB-Lite initiator: commands become NONSEQ/SINGLE transfers, one in-order response each.
// Latency: address phase the cycle after acceptance; response 3 cycles after acceptance with a zero-wait slave.
// Backpressure: cmd_ready low while the address slot is stalled or an ERROR/cancel is resolving; responses never stall.
module ahb_lite_master_port #(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    ahb_lite_master_port_if.master bus
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // address-phase slot contents
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
    } a_slot_t;

    // data-phase slot contents
    typedef struct packed {
        logic        write;
        logic [31:0] wdata;
    } d_slot_t;

    logic        a_valid_q, a_valid_d;
    a_slot_t     a_slot_q, a_slot_d;
    logic        d_valid_q, d_valid_d;
    d_slot_t     d_slot_q, d_slot_d;
    logic        err1_q, err1_d;
    logic        cancel_pend_q, cancel_pend_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic        cmd_ready;
    logic        accept;
    logic        err_start;

    // Command handshake and first-cycle-of-ERROR detection
    always_comb begin
        cmd_ready = ~err1_q & ~cancel_pend_q & (~a_valid_q | bus.HREADY);
        accept    = bus.cmd_valid & cmd_ready;
        err_start = d_valid_q & bus.HRESP & ~bus.HREADY & ~err1_q;
    end

    // Pipeline advance, response generation and error/cancel bookkeeping
    always_comb begin
        a_valid_d     = a_valid_q;
        a_slot_d      = a_slot_q;
        d_valid_d     = d_valid_q;
        d_slot_d      = d_slot_q;
        err1_d        = err1_q;
        cancel_pend_d = cancel_pend_q;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = 1'b0;
        rsp_rdata_d   = '0;

        // completed phase: address slot moves to data slot, data slot retires
        if (bus.HREADY) begin
            d_valid_d = a_valid_q;
            d_slot_d  = '{write: a_slot_q.write, wdata: a_slot_q.wdata};
            a_valid_d = 1'b0;
            err1_d    = 1'b0;
            if (d_valid_q) begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = bus.HRESP;
                rsp_rdata_d = d_slot_q.write ? 32'd0 : bus.HRDATA;
            end
        end

        // an idle address slot may load even during a data-phase wait state
        if (accept) begin
            a_valid_d = 1'b1;
            a_slot_d  = '{addr:  bus.cmd_addr,
                          write: bus.cmd_write,
                          size:  bus.cmd_size,
                          wdata: bus.cmd_wdata};
        end

        // first ERROR cycle: pull the pending address phase off the bus. A command
        // accepted on this same edge is cancelled too, so it still gets a response.
        if (err_start) begin
            err1_d        = 1'b1;
            a_valid_d     = 1'b0;
            cancel_pend_d = a_valid_q | accept;
        end

        // cancelled command reports the cycle after the errored transfer's response
        if (cancel_pend_q && !err1_q && !d_valid_q) begin
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_rdata_d   = '0;
            cancel_pend_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_valid_q     <= 1'b0;
            a_slot_q      <= '0;
            d_valid_q     <= 1'b0;
            d_slot_q      <= '0;
            err1_q        <= 1'b0;
            cancel_pend_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            a_valid_q     <= a_valid_d;
            a_slot_q      <= a_slot_d;
            d_valid_q     <= d_valid_d;
            d_slot_q      <= d_slot_d;
            err1_q        <= err1_d;
            cancel_pend_q <= cancel_pend_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.HTRANS    = a_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HADDR     = a_slot_q.addr;
    assign bus.HWRITE    = a_slot_q.write;
    assign bus.HSIZE     = a_slot_q.size;
    assign bus.HWDATA    = d_valid_q ? d_slot_q.wdata : 32'd0;
    assign bus.HBURST    = 3'b000;
    assign bus.HPROT     = HPROT_VAL;
    assign bus.HMASTLOCK = 1'b0;
endmodule

// File: tb/tb_ahb_lite_master_port.sv
// Self-checking bench for ahb_lite_master_port: directed scenarios plus randomized traffic.
// Latency: checks exact cycle timing in directed tests; transaction order in random traffic.
// Backpressure: bench slave inserts random wait states and two-cycle ERROR responses.
module tb_ahb_lite_master_port;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } cmd_t;

    always #5 clk = ~clk;

    ahb_lite_master_port_if bus();

    ahb_lite_master_port #(.HPROT_VAL(4'b0011)) dut (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_cmd(input logic v, input logic w, input logic [31:0] a,
                             input logic [2:0] s, input logic [31:0] d);
        bus.cmd_valid = v;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_size  = s;
        bus.cmd_wdata = d;
    endtask

    task automatic drive_slave(input logic rdy, input logic resp, input logic [31:0] rd);
        bus.HREADY = rdy;
        bus.HRESP  = resp;
        bus.HRDATA = rd;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [31:0] addr, input logic [2:0] size);
        logic [31:0] m;
        m = (size == 3'd0) ? 32'h0000_00FF : (size == 3'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        m = m << {addr[1:0], 3'b000};
        return (old & ~m) | (nw & m);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive_cmd(1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
        drive_slave(1'b1, 1'b0, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.HTRANS !== 2'b00) begin n_err++; $display("FAIL rst_htrans got %h exp 0", bus.HTRANS); end
        n_cmp++; if (bus.HADDR !== 32'd0) begin n_err++; $display("FAIL rst_haddr got %h exp 0", bus.HADDR); end
        n_cmp++; if ({bus.HWRITE, bus.HSIZE} !== 4'd0) begin n_err++; $display("FAIL rst_hwrite_hsize got %h exp 0", {bus.HWRITE, bus.HSIZE}); end
        n_cmp++; if (bus.HWDATA !== 32'd0) begin n_err++; $display("FAIL rst_hwdata got %h exp 0", bus.HWDATA); end
        n_cmp++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== 34'd0) begin n_err++; $display("FAIL rst_rsp got %b/%b/%h exp 0/0/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready got %b exp 1", bus.cmd_ready); end
        n_cmp++; if ({bus.HBURST, bus.HPROT, bus.HMASTLOCK} !== {3'b000, 4'b0011, 1'b0}) begin n_err++; $display("FAIL rst_consts got %h exp %h", {bus.HBURST, bus.HPROT, bus.HMASTLOCK}, {3'b000, 4'b0011, 1'b0}); end
    endtask

    task automatic test_single_write();
        drive_cmd(1'b1, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF);
        drive_slave(1'b1, 1'b0, 32'd0);
        #1;
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL t1_ready got %b exp 1", bus.cmd_ready); end
        tick();
        bus.cmd_valid = 1'b0;
        n_cmp++; if ({bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HSIZE} !== {2'b10, 32'h10, 1'b1, 3'b010}) begin n_err++; $display("FAIL t1_addr_phase got %h/%h/%b/%h exp 2/10/1/2", bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HSIZE); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL t1_early_rsp got %b exp 0", bus.rsp_valid); end
        tick();
        n_cmp++; if (bus.HTRANS !== 2'b00) begin n_err++; $display("FAIL t1_htrans_idle got %h exp 0", bus.HTRANS); end
        n_cmp++; if (bus.HWDATA !== 32'hDEADBEEF) begin n_err++; $display("FAIL t1_hwdata got %h exp deadbeef", bus.HWDATA); end
        tick();
        n_cmp++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, 32'd0}) begin n_err++; $display("FAIL t1_rsp got %b/%b/%h exp 1/0/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
        tick();
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL t1_rsp_pulse got %b exp 0", bus.rsp_valid); end
    endtask

    task automatic test_read_wait();
        drive_cmd(1'b1, 1'b0, 32'h20, 3'b010, 32'd0);
        drive_slave(1'b1, 1'b0, 32'd0);
        tick();
        drive_cmd(1'b1, 1'b0, 32'h24, 3'b010, 32'd0);
        n_cmp++; if ({bus.HTRANS, bus.HADDR} !== {2'b10, 32'h20}) begin n_err++; $display("FAIL t2_addr got %h/%h exp 2/20", bus.HTRANS, bus.HADDR); end
        #1;
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL t2_ready_b2b got %b exp 1", bus.cmd_ready); end
        tick();
        bus.cmd_valid = 1'b0;
        for (int w = 0; w < 3; w++) begin
            drive_slave(w == 2, 1'b0, (w == 2) ? 32'h12345678 : 32'hFFFF_FFFF);
            n_cmp++; if ({bus.HTRANS, bus.HADDR} !== {2'b10, 32'h24}) begin n_err++; $display("FAIL t2_haddr_held cyc %0d got %h/%h exp 2/24", w, bus.HTRANS, bus.HADDR); end
            n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL t2_rsp_during_wait cyc %0d got %b exp 0", w, bus.rsp_valid); end
            #1;
            n_cmp++; if (bus.cmd_ready !== (w == 2)) begin n_err++; $display("FAIL t2_cmd_ready cyc %0d got %b exp %b", w, bus.cmd_ready, w == 2); end
            tick();
        end
        drive_slave(1'b1, 1'b0, 32'hCAFEF00D);
        n_cmp++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, 32'h12345678}) begin n_err++; $display("FAIL t2_rsp1 got %b/%b/%h exp 1/0/12345678", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
        tick();
        drive_slave(1'b1, 1'b0, 32'd0);
        n_cmp++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin n_err++; $display("FAIL t2_rsp2 got %b/%b/%h exp 1/0/cafef00d", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
        tick();
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL t2_rsp_end got %b exp 0", bus.rsp_valid); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            drive_cmd(k < 4, 1'b0, 32'(4 * k), 3'b010, 32'd0);
            drive_slave(1'b1, 1'b0, (k >= 2 && k < 6) ? 32'hA000_0000 + 32'(k - 2) : 32'd0);
            if (k >= 1 && k <= 4) begin
                n_cmp++; if ({bus.HTRANS, bus.HADDR} !== {2'b10, 32'(4 * (k - 1))}) begin n_err++; $display("FAIL t3_addr cyc %0d got %h/%h exp 2/%h", k, bus.HTRANS, bus.HADDR, 4 * (k - 1)); end
            end
            if (k == 5) begin
                n_cmp++; if (bus.HTRANS !== 2'b00) begin n_err++; $display("FAIL t3_idle got %h exp 0", bus.HTRANS); end
            end
            if (k >= 3 && k <= 6) begin
                n_cmp++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, 32'hA000_0000 + 32'(k - 3)}) begin n_err++; $display("FAIL t3_rsp cyc %0d got %b/%b/%h exp 1/0/%h", k, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, 32'hA000_0000 + 32'(k - 3)); end
            end else begin
                n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL t3_no_rsp cyc %0d got %b exp 0", k, bus.rsp_valid); end
            end
            #1;
            if (k < 4) begin
                n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL t3_ready cyc %0d got %b exp 1", k, bus.cmd_ready); end
            end
            tick();
        end
    endtask

    task automatic test_error_cancel();
        drive_cmd(1'b1, 1'b1, 32'h100, 3'b010, 32'h0BAD_F00D);
        drive_slave(1'b1, 1'b0, 32'd0);
        tick();
        drive_cmd(1'b1, 1'b0, 32'h104, 3'b010, 32'd0);
        n_cmp++; if ({bus.HTRANS, bus.HADDR} !== {2'b10, 32'h100}) begin n_err++; $display("FAIL t4_addr got %h/%h exp 2/100", bus.HTRANS, bus.HADDR); end
        tick();
        bus.cmd_valid = 1'b0;
        drive_slave(1'b0, 1'b1, 32'd0);
        n_cmp++; if (bus.HWDATA !== 32'h0BAD_F00D) begin n_err++; $display("FAIL t4_hwdata got %h exp 0badf00d", bus.HWDATA); end
        tick();
        drive_slave(1'b1, 1'b1, 32'h5555_5555);
        n_cmp++; if (bus.HTRANS !== 2'b00) begin n_err++; $display("FAIL t4_err2_idle got %h exp 0", bus.HTRANS); end
        #1;
        n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL t4_ready_err got %b exp 0", bus.cmd_ready); end
        tick();
        drive_slave(1'b1, 1'b0, 32'd0);
        n_cmp++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b1, 32'd0}) begin n_err++; $display("FAIL t4_rsp_err got %b/%b/%h exp 1/1/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
        n_cmp++; if (bus.HTRANS !== 2'b00) begin n_err++; $display("FAIL t4_no_read_issue got %h exp 0", bus.HTRANS); end
        #1;
        n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL t4_ready_cancel got %b exp 0", bus.cmd_ready); end
        tick();
        n_cmp++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b1, 32'd0}) begin n_err++; $display("FAIL t4_rsp_cancel got %b/%b/%h exp 1/1/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
        n_cmp++; if (bus.HTRANS !== 2'b00) begin n_err++; $display("FAIL t4_no_read_issue2 got %h exp 0", bus.HTRANS); end
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL t4_ready_after got %b exp 1", bus.cmd_ready); end
        tick();
        n_cmp++; if ({bus.rsp_valid, bus.HTRANS} !== 3'b000) begin n_err++; $display("FAIL t4_quiet got %b/%h exp 0/0", bus.rsp_valid, bus.HTRANS); end
    endtask

    task automatic test_byte_write();
        drive_cmd(1'b1, 1'b1, 32'h3, 3'b000, 32'hAB00_0000);
        drive_slave(1'b1, 1'b0, 32'd0);
        tick();
        bus.cmd_valid = 1'b0;
        n_cmp++; if ({bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HSIZE} !== {2'b10, 32'h3, 1'b1, 3'b000}) begin n_err++; $display("FAIL t5_addr got %h/%h/%b/%h exp 2/3/1/0", bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HSIZE); end
        tick();
        n_cmp++; if (bus.HWDATA !== 32'hAB00_0000) begin n_err++; $display("FAIL t5_hwdata got %h exp ab000000", bus.HWDATA); end
        tick();
        n_cmp++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, 32'd0}) begin n_err++; $display("FAIL t5_rsp got %b/%b/%h exp 1/0/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        drive_cmd(1'b1, 1'b0, 32'h40, 3'b010, 32'd0);
        drive_slave(1'b1, 1'b0, 32'd0);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        drive_slave(1'b0, 1'b0, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if ({bus.HTRANS, bus.HWDATA} !== 34'd0) begin n_err++; $display("FAIL t6_bus_idle got %h/%h exp 0/0", bus.HTRANS, bus.HWDATA); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL t6_no_rsp got %b exp 0", bus.rsp_valid); end
        #1;
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL t6_ready got %b exp 1", bus.cmd_ready); end
        // completing the stale data phase, then a stray ERROR on an idle bus: no response either way
        for (int k = 0; k < 5; k++) begin
            drive_slave(k != 3, k == 3 || k == 4, 32'd0);
            tick();
            n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL t6_stray_rsp cyc %0d got %b exp 0", k, bus.rsp_valid); end
        end
        drive_slave(1'b1, 1'b0, 32'd0);
        #1;
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL t6_ready_end got %b exp 1", bus.cmd_ready); end
    endtask

    task automatic test_random();
        cmd_t        pend[$];
        logic [32:0] expq[$];
        logic [31:0] mem [0:15];
        logic [32:0] exp_r;
        cmd_t        c;
        cmd_t        dp;
        bit          dp_vld;
        bit          dp_err;
        bit          err_stage;
        int          waits;
        logic        hready;
        logic        hresp;
        logic [31:0] hrdata;
        logic [1:0]  lo;
        dp_vld = 1'b0; dp_err = 1'b0; err_stage = 1'b0; waits = 0;
        dp = '{write: 1'b0, addr: 32'd0, size: 3'd0, wdata: 32'd0};
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (bus.rsp_valid === 1'b1) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_err++; $display("FAIL rnd_unexpected_rsp cyc %0d got %b/%h exp none", cyc, bus.rsp_err, bus.rsp_rdata);
                end else begin
                    exp_r = expq.pop_front();
                    if ({bus.rsp_err, bus.rsp_rdata} !== exp_r) begin n_err++; $display("FAIL rnd_rsp cyc %0d got %b/%h exp %b/%h", cyc, bus.rsp_err, bus.rsp_rdata, exp_r[32], exp_r[31:0]); end
                end
            end
            hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
            if (dp_vld) begin
                if (waits > 0) begin
                    hready = 1'b0; waits--;
                end else if (dp_err && !err_stage) begin
                    hready = 1'b0; hresp = 1'b1; err_stage = 1'b1;
                end else if (dp_err) begin
                    hresp = 1'b1;
                end else if (!dp.write) begin
                    hrdata = mem[dp.addr[5:2]];
                end
            end
            drive_slave(hready, hresp, hrdata);
            c.write = 1'($urandom_range(0, 1));
            c.size  = 3'($urandom_range(0, 2));
            case (c.size)
                3'd0:    lo = 2'($urandom_range(0, 3));
                3'd1:    lo = {1'($urandom_range(0, 1)), 1'b0};
                default: lo = 2'b00;
            endcase
            c.addr  = {26'd0, 4'($urandom_range(0, 15)), lo};
            c.wdata = $urandom;
            drive_cmd((cyc < 2500) && ($urandom_range(0, 3) != 0), c.write, c.addr, c.size, c.wdata);
            #1;
            if (bus.cmd_valid && bus.cmd_ready === 1'b1) pend.push_back(c);
            if (hready) begin
                if (dp_vld) begin
                    if (dp.write) begin
                        n_cmp++; if (bus.HWDATA !== dp.wdata) begin n_err++; $display("FAIL rnd_hwdata cyc %0d got %h exp %h", cyc, bus.HWDATA, dp.wdata); end
                    end
                    if (dp_err) begin
                        expq.push_back({1'b1, dp.write ? 32'd0 : hrdata});
                        while (pend.size() > 0) begin
                            void'(pend.pop_front());
                            expq.push_back({1'b1, 32'd0});
                        end
                    end else begin
                        if (dp.write) mem[dp.addr[5:2]] = merge(mem[dp.addr[5:2]], dp.wdata, dp.addr, dp.size);
                        expq.push_back({1'b0, dp.write ? 32'd0 : hrdata});
                    end
                    dp_vld = 1'b0;
                end
                if (bus.HTRANS === 2'b10) begin
                    n_cmp++;
                    if (pend.size() == 0) begin
                        n_err++; $display("FAIL rnd_unexpected_nonseq cyc %0d got %h exp idle", cyc, bus.HADDR);
                    end else begin
                        c = pend.pop_front();
                        if ({bus.HADDR, bus.HWRITE, bus.HSIZE} !== {c.addr, c.write, c.size}) begin n_err++; $display("FAIL rnd_addr_phase cyc %0d got %h/%b/%h exp %h/%b/%h", cyc, bus.HADDR, bus.HWRITE, bus.HSIZE, c.addr, c.write, c.size); end
                        dp = c; dp_vld = 1'b1;
                        waits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
                        dp_err = ($urandom_range(0, 9) == 0);
                        err_stage = 1'b0;
                    end
                end
            end
            tick();
        end
        n_cmp++; if (pend.size() != 0 || dp_vld) begin n_err++; $display("FAIL rnd_drain_bus got %0d/%b exp 0/0", pend.size(), dp_vld); end
        n_cmp++; if (expq.size() != 0) begin n_err++; $display("FAIL rnd_drain_rsp got %0d exp 0", expq.size()); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_wait();
        test_back_to_back();
        test_error_cancel();
        test_byte_write();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
